// File: rtl/seq_tx_1011_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_tx_1011_if
//  Description : Payload handshake bundle for the 1011 frame transmitter.
//                The producer drives data_in/data_valid, and the transmitter
//                answers with data_ready.
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_tx_1011_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface
`default_nettype wire

// File: rtl/seq_tx_1011.sv
`default_nettype none
// ============================================================================
//  Module      : seq_tx_1011
//  Description : Serial frame transmitter. Each accepted payload word is sent
//                one bit per clock as a 1011 preamble, then the payload
//                MSB-first, then an idle-low gap. All outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_tx_1011 #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  wire logic       clk,
  input  wire logic       reset,
  seq_tx_1011_if.slave    bus,
  output logic            out_bit,
  output logic            out_valid,
  output logic            busy,
  output logic            done,
  output logic [7:0]      frame_cnt
);

  // The counter also sequences the 4-cycle preamble, so 4 joins the maximum.
  localparam int CNT_MAX = (DATA_W > GAP_CYCLES)
                           ? ((DATA_W > 4) ? DATA_W : 4)
                           : ((GAP_CYCLES > 4) ? GAP_CYCLES : 4);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SH_W    = DATA_W + 4;

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_PAYLOAD  = 2'd2,
    S_GAP      = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [SH_W-1:0]   sh;
  logic              ready_reg;

  assign bus.data_ready = ready_reg;

  // Frame sequencer. The preamble tail and the payload share one shift
  // register; its MSB is the next line bit. The first preamble '1' is
  // driven directly at the accept edge, so only "011" is stored ahead of
  // the payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sh        <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= 8'd0;
      ready_reg <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.data_valid) begin
            state     <= S_PREAMBLE;
            cnt       <= '0;
            sh        <= {3'b011, bus.data_in, 1'b0};
            out_bit   <= 1'b1;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            ready_reg <= 1'b0;
          end else begin
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            ready_reg <= 1'b1;
          end
        end

        S_PREAMBLE: begin
          out_bit <= sh[SH_W-1];
          sh      <= {sh[SH_W-2:0], 1'b0};
          if (cnt == PRE_LAST) begin
            state <= S_PAYLOAD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_PAYLOAD: begin
          if (cnt == PAY_LAST) begin
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
            cnt       <= '0;
            if (GAP_CYCLES > 0) begin
              state <= S_GAP;
            end else begin
              // No gap: the done cycle is already IDLE, allowing a gapless stream.
              state     <= S_IDLE;
              busy      <= 1'b0;
              ready_reg <= 1'b1;
            end
          end else begin
            out_bit <= sh[SH_W-1];
            sh      <= {sh[SH_W-2:0], 1'b0};
            cnt     <= cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (cnt == GAP_LAST) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            ready_reg <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          cnt       <= '0;
          out_bit   <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_tx_1011.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_tx_1011
//  Description : Directed self-checking bench for seq_tx_1011. Covers a
//                GAP_CYCLES=2 instance and a GAP_CYCLES=0 instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_tx_1011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_tx_1011_if #(.DATA_W(8)) bus_a ();
  seq_tx_1011_if #(.DATA_W(8)) bus_z ();

  logic       out_bit_a, out_valid_a, busy_a, done_a;
  logic [7:0] frame_cnt_a;
  logic       out_bit_z, out_valid_z, busy_z, done_z;
  logic [7:0] frame_cnt_z;

  seq_tx_1011 #(.DATA_W(8), .GAP_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_a),
    .out_bit   (out_bit_a),
    .out_valid (out_valid_a),
    .busy      (busy_a),
    .done      (done_a),
    .frame_cnt (frame_cnt_a)
  );

  seq_tx_1011 #(.DATA_W(8), .GAP_CYCLES(0)) dut_gap0 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_z),
    .out_bit   (out_bit_z),
    .out_valid (out_valid_z),
    .busy      (busy_z),
    .done      (done_z),
    .frame_cnt (frame_cnt_z)
  );

  // Status word: {data_ready, out_valid, out_bit, busy, done, frame_cnt}
  logic [12:0] st_a, st_z;
  assign st_a = {bus_a.data_ready, out_valid_a, out_bit_a, busy_a, done_a, frame_cnt_a};
  assign st_z = {bus_z.data_ready, out_valid_z, out_bit_z, busy_z, done_z, frame_cnt_z};

  localparam logic [12:0] IDLE_ST = 13'h1000;

  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] line, vln, mask;
  logic [3:0]  hist;
  logic [11:0] pat;
  logic [12:0] exp_st;
  logic [7:0]  fc254;
  int          dn, errs;

  initial begin
    // ---- reset held with data_valid high: no accept, idle outputs
    bus_a.data_in = 8'h5A; bus_a.data_valid = 1'b1;
    bus_z.data_in = 8'h5A; bus_z.data_valid = 1'b1;
    reset = 1'b1;
    tick;
    check("rst_a_c1", 32'(st_a), 32'(IDLE_ST));
    check("rst_z_c1", 32'(st_z), 32'(IDLE_ST));
    tick;
    check("rst_a_c2", 32'(st_a), 32'(IDLE_ST));
    check("rst_z_c2", 32'(st_z), 32'(IDLE_ST));
    reset = 1'b0;
    bus_a.data_valid = 1'b0;
    bus_z.data_valid = 1'b0;
    tick;
    check("rst_a_rel", 32'(st_a), 32'(IDLE_ST));
    check("rst_z_rel", 32'(st_z), 32'(IDLE_ST));

    // ---- single frame 0xA5
    bus_a.data_in = 8'hA5; bus_a.data_valid = 1'b1;
    tick;
    bus_a.data_valid = 1'b0; bus_a.data_in = 8'h00;
    check("a5_ready_low", 32'(bus_a.data_ready), 32'd0);
    line = '0; vln = '0; dn = 0;
    for (int i = 0; i < 12; i++) begin
      line = {line[30:0], out_bit_a};
      vln  = {vln[30:0], out_valid_a};
      dn  += int'(done_a);
      tick;
    end
    check("a5_line", line, 32'h0000_0BA5);
    check("a5_valid", vln, 32'h0000_0FFF);
    check("a5_no_early_done", 32'(dn), 32'd0);
    check("a5_done_k13", 32'(st_a), 32'h0301);
    tick;
    check("a5_gap_k14", 32'(st_a), 32'h0201);
    tick;
    check("a5_idle_k15", 32'(st_a), 32'h1001);

    // ---- back-to-back 0xFF then 0x00 with data_valid held high
    bus_a.data_in = 8'hFF; bus_a.data_valid = 1'b1;
    tick;
    bus_a.data_in = 8'h00;
    line = '0; vln = '0; dn = 0;
    for (int i = 0; i < 27; i++) begin
      line = {line[30:0], out_bit_a};
      vln  = {vln[30:0], out_valid_a};
      dn  += int'(done_a);
      tick;
    end
    bus_a.data_valid = 1'b0;
    check("b2b_line", line, 32'h05FF_8B00);
    check("b2b_valid", vln, 32'h07FF_8FFF);
    check("b2b_mid_done", 32'(dn), 32'd1);
    check("b2b_done2", 32'(st_a), 32'h0303);
    tick;
    tick;
    check("b2b_idle", 32'(st_a), 32'h1003);

    // ---- loopback into a 1011 detector, payload 0x0B
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("lb_rst", 32'(st_a), 32'(IDLE_ST));
    bus_a.data_in = 8'h0B; bus_a.data_valid = 1'b1;
    tick;
    bus_a.data_valid = 1'b0;
    hist = '0; mask = '0; line = '0;
    for (int i = 0; i < 12; i++) begin
      hist = {hist[2:0], out_bit_a};
      line = {line[30:0], out_bit_a};
      if (out_valid_a && hist == 4'b1011) mask[i] = 1'b1;
      tick;
    end
    check("lb_line", line, 32'h0000_0B0B);
    check("lb_hits", mask, 32'h0000_0808);
    check("lb_done", 32'(st_a), 32'h0301);
    tick;
    tick;
    check("lb_idle", 32'(st_a), 32'h1001);

    // ---- reset during payload bit 3 of 0x3C
    bus_a.data_in = 8'h3C; bus_a.data_valid = 1'b1;
    tick;
    bus_a.data_valid = 1'b0;
    repeat (7) tick;
    check("mid_bit3", 32'({out_valid_a, out_bit_a}), 32'h3);
    reset = 1'b1;
    tick;
    check("mid_abort", 32'(st_a), 32'(IDLE_ST));
    reset = 1'b0;
    tick;
    check("mid_after", 32'(st_a), 32'(IDLE_ST));
    bus_a.data_in = 8'hC3; bus_a.data_valid = 1'b1;
    tick;
    bus_a.data_valid = 1'b0;
    line = '0;
    for (int i = 0; i < 12; i++) begin
      line = {line[30:0], out_bit_a};
      tick;
    end
    check("mid_next_line", line, 32'h0000_0BC3);
    check("mid_next_done", 32'(st_a), 32'h0301);

    // ---- GAP_CYCLES=0: 256 gapless frames of 0x01, frame_cnt wraps
    pat = 12'hB01;
    bus_z.data_in = 8'h01; bus_z.data_valid = 1'b1;
    tick;
    errs = 0; dn = 0; fc254 = 8'h00;
    for (int f = 0; f < 256; f++) begin
      for (int p = 0; p < 13; p++) begin
        if (p < 12) exp_st = {1'b0, 1'b1, pat[11-p], 1'b1, 1'b0, 8'(f)};
        else        exp_st = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'(f + 1)};
        if (st_z !== exp_st) errs++;
        dn += int'(done_z);
        if (f == 254 && p == 12) fc254 = frame_cnt_z;
        if (f == 255 && p == 12) bus_z.data_valid = 1'b0;
        tick;
      end
    end
    check("g0_stream_errs", 32'(errs), 32'd0);
    check("g0_done_pulses", 32'(dn), 32'd256);
    check("g0_cnt_255", 32'(fc254), 32'd255);
    check("g0_wrap_idle", 32'(st_z), 32'(IDLE_ST));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
